calc_display: RTL
=================

# calc_display

Receiver for the calculator's scanned digit output. Samples the `data`/`pos` stream, one BCD digit per clock, and checks the position sequence. Complete frames are committed to a double buffer, so the displays never show a torn frame. Drives an 8-digit multiplexed, active-low seven-segment display, with leading-zero blanking and status overlays for error and busy.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each physical digit stays lit; legal range ≥1.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros above the most significant nonzero digit; 0 shows all eight digits.
- `clock`  in  1  system clock; same clock as the calculator core.
- `reset`  in  1  asynchronous, active-high.
- `data`  in  4  BCD digit for position `pos`.
- `pos`  in  4  digit index; 0..7 valid, values >7 are the inter-frame gap.
- `status`  in  2  calculator status: 00 error, 01 busy, 10 ready, 11 idle.
- `an`  out  8  digit enables, active-low; `an[i]` is digit i, with digit 0 the least significant.
- `seg`  out  8  segments, active-low; bit 0 = a … bit 6 = g, bit 7 = dp (dp always off, i.e. 1).
- `frame_valid`  out  1  one-cycle pulse after each committed frame.
- `sync_err`  out  1  one-cycle pulse on a position-sequence violation.

## Operation
- **Capture.** Each edge where `pos` ≤ 7 and capture is active writes `data` into `shadow[pos]`.
- **Frame tracking:**
  - `pos`==0 always starts a frame: set `in_frame`=1 and `exp`=1, and write `shadow[0]`.
  - `pos` in 1..7 with `in_frame`=0 is ignored.
  - `pos` in 1..7 with `pos`==`exp`: write the digit and increment `exp`.
  - `pos` in 1..7 with `pos`≠`exp`: clear `in_frame`, pulse `sync_err`, and leave the display buffer untouched until the next `pos`==0.
  - `pos` > 7 is ignored and does not break the frame.
- **Commit.** At the edge where `pos`==7 is accepted, `disp[7:0]` takes `shadow[6:0]` plus the current `data`. `frame_valid` pulses the following cycle and `in_frame` clears.
- **Digit sanitising.** A captured value >9 displays as blank.
- **Leading-zero blanking** (`BLANK_LEADING`=1): digits above the highest nonzero `disp` index are blank. Digit 0 is always shown, so an all-zero buffer shows a single "0".
- **Overlay.** Uses live `status`, sampled each edge:
  - 00: digits 3..0 show E, r, r, o; digits 7..4 are blank.
  - 01: all digits show dash.
  - 10 or 11: the buffer is shown.
- **Scan.** `rcnt` counts 0..`REFRESH_DIV`-1. At wrap, `scan` advances 0→7 and then back to 0.
  - `an` = ~(1<<`scan`).
  - `seg` = encoding of the glyph selected for digit `scan`.

## Timing
- **Reset values:** `an`=FF, `seg`=FF, `frame_valid`=0, `sync_err`=0, `scan`=0, `rcnt`=0, `in_frame`=0, `exp`=0, `shadow`=0, `disp`=0.
- **Reset mid-frame:** discards the partial frame; the buffer returns to 0.
- `an`/`seg` are registered: one cycle of latency after a change to `scan`, `disp` or `status`.
- **Frame latency:** the pos-7 sample at edge k is visible in `disp` after k. It is visible on `seg` after edge k+1, provided that digit is currently scanned. `frame_valid` is high during cycle k→k+1.
- **Scan timing:** each digit is enabled for exactly `REFRESH_DIV` cycles, giving a full scan of 8·`REFRESH_DIV` cycles. With `REFRESH_DIV`=1, `scan` advances every cycle.
- **Calculator cadence:** 9 cycles per frame (pos 0..8), so a frame commits every 9 cycles in steady state.
- **Simultaneous events:**
  - `sync_err` and `frame_valid` never pulse in the same cycle.
  - A `pos`==0 that arrives while `in_frame`=1 restarts the frame silently, without `sync_err`.

## Structure
- Package `calc_disp_pkg`:
  - glyph enum: D0–D9, BLANK, DASH, E, R, O.
  - segment constants, active-low:
    - digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
    - symbols: BLANK=FF, DASH=BF, E=86, r=AF, o=A3.
  - status constants: ST_ERR=00, ST_BUSY=01, ST_READY=10, ST_IDLE=11.
- Sub-module `seg7_encode` (combinational): glyph → `seg`.
- The top level holds capture/frame tracking, blanking/overlay selection, and the refresh/scan counters.

## Test plan
- **Normal frame, blanking on:** `REFRESH_DIV`=1, `status`=10; feed pos 0..8 with data 4,3,2,1,0,0,0,0,0.
  - `frame_valid` pulses once.
  - Scanning gives `seg`: digit 0=99, 1=B0, 2=A4, 3=F9, digits 4..7=FF.
  - `an` steps FE, FD, FB, …, 7F, then back to FE.
- **All-zero frame:**
  - Blanking on: digit 0 = C0, others FF.
  - `BLANK_LEADING`=0: all digits C0.
- **Error overlay:** `status`=00 with any buffer.
  - Digits 3..0 = 86, AF, AF, A3; digits 7..4 = FF.
  - `status`=01: all digits BF.
- **Sequence violation:** pos 0,1,3.
  - `sync_err` pulses once on the pos-3 edge; `frame_valid` stays low.
  - The displayed buffer keeps the prior frame.
  - The next clean 0..7 sequence commits normally.
- **Reset mid-frame:** assert `reset` after pos 4 of a frame.
  - `an`=FF and `seg`=FF immediately.
  - After release and a frame of 7s, all digits show F8 and `frame_valid` pulses.
- **Refresh period:** `REFRESH_DIV`=4.
  - Each `an` value persists exactly 4 cycles.
  - Full scan takes 32 cycles; `scan` wraps from 7 to 0.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display receiver:
// glyph codes, active-low segment patterns and calculator status codes.
package calc_disp_pkg;

    typedef enum logic [3:0] {
        D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
        BLANK, DASH, E, R, O
    } glyph_t;

    typedef enum logic {
        FR_IDLE,
        FR_ACTIVE
    } frame_state_t;

    localparam logic [7:0] SEG_D0    = 8'hC0;
    localparam logic [7:0] SEG_D1    = 8'hF9;
    localparam logic [7:0] SEG_D2    = 8'hA4;
    localparam logic [7:0] SEG_D3    = 8'hB0;
    localparam logic [7:0] SEG_D4    = 8'h99;
    localparam logic [7:0] SEG_D5    = 8'h92;
    localparam logic [7:0] SEG_D6    = 8'h82;
    localparam logic [7:0] SEG_D7    = 8'hF8;
    localparam logic [7:0] SEG_D8    = 8'h80;
    localparam logic [7:0] SEG_D9    = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_O     = 8'hA3;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_IDLE  = 2'b11;

    // Non-BCD captures render as blank rather than garbage segments.
    function automatic glyph_t digit_glyph(input logic [3:0] value);
        return (value <= 4'd9) ? glyph_t'(value) : BLANK;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Glyph to active-low seven-segment pattern; bit 0 = a .. bit 6 = g, bit 7 = dp (kept off).
module seg7_encode
    import calc_disp_pkg::*;
(
    input  logic [3:0] glyph,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph_t'(glyph))
            D0:      seg = SEG_D0;
            D1:      seg = SEG_D1;
            D2:      seg = SEG_D2;
            D3:      seg = SEG_D3;
            D4:      seg = SEG_D4;
            D5:      seg = SEG_D5;
            D6:      seg = SEG_D6;
            D7:      seg = SEG_D7;
            D8:      seg = SEG_D8;
            D9:      seg = SEG_D9;
            DASH:    seg = SEG_DASH;
            E:       seg = SEG_E;
            R:       seg = SEG_R;
            O:       seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Receives the calculator's scanned digit stream, commits whole frames to a
// display buffer and drives an 8-digit multiplexed active-low 7-seg display.
module calc_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_valid,
    output logic       sync_err
);

    localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REFRESH_DIV - 1);

    frame_state_t      frame_state;
    frame_state_t      frame_next;
    logic [3:0]        exp_pos;
    logic [3:0]        exp_next;
    logic              shadow_we;
    logic              commit;
    logic              seq_err;

    logic [3:0]        shadow [0:7];
    logic [3:0]        disp   [0:7];

    logic [RCNT_W-1:0] rcnt;
    logic [2:0]        scan;
    logic [2:0]        msd;
    glyph_t            sel_glyph;
    logic [7:0]        seg_next;

    // Frame tracking: decides what the current pos/data sample does.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
        frame_next = frame_state;
        exp_next   = exp_pos;
        shadow_we  = 1'b0;
        commit     = 1'b0;
        seq_err    = 1'b0;

        if (pos == 4'd0) begin
            frame_next = FR_ACTIVE;
            exp_next   = 4'd1;
            shadow_we  = 1'b1;
        end else if (pos <= 4'd7 && frame_state == FR_ACTIVE) begin
            if (pos == exp_pos) begin
                if (pos == 4'd7) begin
                    commit     = 1'b1;
                    frame_next = FR_IDLE;
                    exp_next   = 4'd0;
                end else begin
                    shadow_we = 1'b1;
                    exp_next  = exp_pos + 4'd1;
                end
            end else begin
                frame_next = FR_IDLE;
                seq_err    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_state <= FR_IDLE;
            exp_pos     <= 4'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            // NOTE: shadow and disp are eight-entry flop arrays, not RAM, so they clear with the rest of the state.
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'd0;
                disp[i]   <= 4'd0;
            end
        end else begin
            // NOTE: non-blocking updates here so every flop samples pre-edge values regardless of statement order.
            frame_state <= frame_next;
            exp_pos     <= exp_next;
            frame_valid <= commit;
            sync_err    <= seq_err;
            if (shadow_we) begin
                shadow[pos[2:0]] <= data;
            end
            // The last digit bypasses the shadow so the commit needs no extra cycle.
            if (commit) begin
                for (int i = 0; i < 7; i++) begin
                    disp[i] <= shadow[i];
                end
                disp[7] <= data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rcnt <= '0;
            scan <= 3'd0;
        end else if (rcnt == RCNT_MAX) begin
            rcnt <= '0;
            scan <= scan + 3'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // Highest nonzero buffer index; digit 0 is always lit.
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (disp[i] != 4'd0) begin
                msd = 3'(i);
            end
        end
    end

    always_comb begin
        sel_glyph = BLANK;
        case (status)
            ST_ERR: begin
                case (scan)
                    3'd3:    sel_glyph = E;
                    3'd2:    sel_glyph = R;
                    3'd1:    sel_glyph = R;
                    3'd0:    sel_glyph = O;
                    default: sel_glyph = BLANK;
                endcase
            end
            ST_BUSY: sel_glyph = DASH;
            default: begin
                if (BLANK_LEADING && (scan > msd)) begin
                    sel_glyph = BLANK;
                end else begin
                    sel_glyph = digit_glyph(disp[scan]);
                end
            end
        endcase
    end

    seg7_encode u_encode (
        .glyph (sel_glyph),
        .seg   (seg_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'd1 << scan);
            seg <= seg_next;
        end
    end

endmodule
